// File: rtl/sram_dma_master.sv
// Fill/copy DMA engine driving an SRAM controller stb/ACK port.
// One word per request; every acknowledged request is followed by a one-cycle idle gap.
module sram_dma_master #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 48
) (
   input  logic              clk_50mhz,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] len,
   input  logic [DATA_W-1:0] fill_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] words_done,
   output logic              m_stb,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addra,
   output logic [DATA_W-1:0] m_dina,
   input  logic [DATA_W-1:0] m_douta,
   input  logic              m_ACK
);

   typedef enum logic [2:0] {IDLE, RD, WR, GAP, FIN} state_t;

   state_t              state_q, state_d;
   state_t              gap_next_q, gap_next_d;
   logic                mode_q, mode_d;
   logic [ADDR_W-1:0]   src_q, src_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [ADDR_W-1:0]   len_q, len_d;
   logic [DATA_W-1:0]   fill_q, fill_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ADDR_W-1:0]   words_done_q, words_done_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                stb_q, stb_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   dina_q, dina_d;

   logic [ADDR_W-1:0]   src_inc, dst_inc, wd_inc;

   assign src_inc = src_q + ADDR_W'(1);
   assign dst_inc = dst_q + ADDR_W'(1);
   assign wd_inc  = words_done_q + ADDR_W'(1);

   // Outputs are computed for the state being entered so they appear on the same edge.
   always_comb begin
      state_d      = state_q;
      gap_next_d   = gap_next_q;
      mode_d       = mode_q;
      src_d        = src_q;
      dst_d        = dst_q;
      len_d        = len_q;
      fill_d       = fill_q;
      data_d       = data_q;
      words_done_d = words_done_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      stb_d        = stb_q;
      we_d         = we_q;
      addr_d       = addr_q;
      dina_d       = dina_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d       = mode;
               src_d        = src_addr;
               dst_d        = dst_addr;
               len_d        = len;
               fill_d       = fill_data;
               words_done_d = '0;
               if (len == '0) begin
                  state_d = FIN;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  stb_d   = 1'b0;
               end else if (mode) begin
                  state_d = RD;
                  busy_d  = 1'b1;
                  stb_d   = 1'b1;
                  we_d    = 1'b0;
                  addr_d  = src_addr;
               end else begin
                  state_d = WR;
                  busy_d  = 1'b1;
                  stb_d   = 1'b1;
                  we_d    = 1'b1;
                  addr_d  = dst_addr;
                  dina_d  = fill_data;
               end
            end
         end
         RD: begin
            if (m_ACK) begin
               data_d     = m_douta;
               src_d      = src_inc;
               state_d    = GAP;
               gap_next_d = WR;
               stb_d      = 1'b0;
            end
         end
         WR: begin
            if (m_ACK) begin
               dst_d        = dst_inc;
               words_done_d = wd_inc;
               stb_d        = 1'b0;
               if (wd_inc == len_q) begin
                  state_d = FIN;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d    = GAP;
                  gap_next_d = mode_q ? RD : WR;
               end
            end
         end
         GAP: begin
            state_d = gap_next_q;
            stb_d   = 1'b1;
            if (gap_next_q == RD) begin
               we_d   = 1'b0;
               addr_d = src_q;
            end else begin
               we_d   = 1'b1;
               addr_d = dst_q;
               dina_d = mode_q ? data_q : fill_q;
            end
         end
         FIN: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         state_q      <= IDLE;
         gap_next_q   <= IDLE;
         mode_q       <= 1'b0;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         fill_q       <= '0;
         data_q       <= '0;
         words_done_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         stb_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         dina_q       <= '0;
      end else begin
         state_q      <= state_d;
         gap_next_q   <= gap_next_d;
         mode_q       <= mode_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         len_q        <= len_d;
         fill_q       <= fill_d;
         data_q       <= data_d;
         words_done_q <= words_done_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         stb_q        <= stb_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         dina_q       <= dina_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign words_done = words_done_q;
   assign m_stb      = stb_q;
   assign m_we       = we_q;
   assign m_addra    = addr_q;
   assign m_dina     = dina_q;

endmodule

// File: tb/tb_sram_dma_master.sv
// Directed bench for sram_dma_master: SRAM responder, bus monitor, one task per scenario.
module tb_sram_dma_master;

   logic        clk;
   logic        rst;
   logic        start;
   logic        mode;
   logic [19:0] src_addr, dst_addr, len;
   logic [47:0] fill_data;
   logic        busy, done;
   logic [19:0] words_done;
   logic        m_stb, m_we;
   logic [19:0] m_addra;
   logic [47:0] m_dina, m_douta;
   logic        m_ACK;

   int compared   = 0;
   int mismatched = 0;

   sram_dma_master #(.ADDR_W(20), .DATA_W(48)) dut (
      .clk_50mhz (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len       (len),
      .fill_data (fill_data),
      .busy      (busy),
      .done      (done),
      .words_done(words_done),
      .m_stb     (m_stb),
      .m_we      (m_we),
      .m_addra   (m_addra),
      .m_dina    (m_dina),
      .m_douta   (m_douta),
      .m_ACK     (m_ACK)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   function automatic logic [47:0] mem_word(input logic [19:0] a);
      case (a)
         20'h00100: return 48'h111111111111;
         20'h00101: return 48'h222222222222;
         default:   return {28'hDEADBEE, a};
      endcase
   endfunction

   // SRAM responder: ACK after ack_delay waiting cycles; optional spurious ACK during a gap.
   int ack_delay   = 1;
   bit resp_en     = 1'b1;
   int spur_req    = 0;
   int spur_served = 0;

   initial begin
      int wait_cnt;
      wait_cnt = 0;
      m_ACK    = 1'b0;
      m_douta  = '0;
      forever begin
         @(posedge clk);
         #1;
         m_ACK = 1'b0;
         if (spur_req != spur_served && !m_stb && busy) begin
            m_ACK = 1'b1;
            spur_served++;
         end else if (m_stb && resp_en) begin
            if (wait_cnt >= ack_delay) begin
               m_ACK    = 1'b1;
               m_douta  = mem_word(m_addra);
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Bus monitor: logs accepted transfers, counts done pulses, strobe cycles and protocol errors.
   logic        log_we[$];
   logic [19:0] log_addr[$];
   logic [47:0] log_data[$];
   int          done_cnt  = 0;
   int          stb_cnt   = 0;
   int          gap_err   = 0;
   int          hold_err  = 0;
   bit          after_ack = 1'b0;
   int          gap_cnt   = 0;
   bit          hold_pend = 1'b0;
   logic        p_we;
   logic [19:0] p_addr;
   logic [47:0] p_dina;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (m_stb === 1'b1) stb_cnt <= stb_cnt + 1;
      if (m_stb === 1'b1 && m_ACK === 1'b1) begin
         log_we.push_back(m_we);
         log_addr.push_back(m_addra);
         log_data.push_back(m_dina);
         after_ack <= 1'b1;
         gap_cnt   <= 0;
      end else if (after_ack) begin
         if (m_stb === 1'b1) begin
            if (gap_cnt != 1) gap_err <= gap_err + 1;
            after_ack <= 1'b0;
         end else if (busy !== 1'b1) begin
            after_ack <= 1'b0;
         end else begin
            gap_cnt <= gap_cnt + 1;
         end
      end
      if (hold_pend && m_stb === 1'b1) begin
         if (m_we !== p_we || m_addra !== p_addr || m_dina !== p_dina) hold_err <= hold_err + 1;
      end
      hold_pend <= (m_stb === 1'b1) && (m_ACK !== 1'b1);
      p_we      <= m_we;
      p_addr    <= m_addra;
      p_dina    <= m_dina;
   end

   // Drives a one-cycle start, then scrambles the command inputs; returns at sampling edge + 1.
   task automatic issue(input logic md, input logic [19:0] s, input logic [19:0] d,
                        input logic [19:0] l, input logic [47:0] f);
      @(posedge clk);
      #1;
      start     = 1'b1;
      mode      = md;
      src_addr  = s;
      dst_addr  = d;
      len       = l;
      fill_data = f;
      @(posedge clk);
      #1;
      start     = 1'b0;
      mode      = ~md;
      src_addr  = 20'h0BAD0;
      dst_addr  = 20'h0BAD1;
      len       = 20'h00077;
      fill_data = 48'hBADBADBADBAD;
   endtask

   task automatic wait_done(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b want=0", busy); end
      compared++;
      if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got=%b want=0", done); end
      compared++;
      if (m_stb !== 1'b0) begin mismatched++; $display("FAIL reset_stb got=%b want=0", m_stb); end
      compared++;
      if (m_we !== 1'b0) begin mismatched++; $display("FAIL reset_we got=%b want=0", m_we); end
      compared++;
      if (m_addra !== 20'h0) begin mismatched++; $display("FAIL reset_addr got=%h want=0", m_addra); end
      compared++;
      if (m_dina !== 48'h0) begin mismatched++; $display("FAIL reset_dina got=%h want=0", m_dina); end
      compared++;
      if (words_done !== 20'h0) begin mismatched++; $display("FAIL reset_words got=%h want=0", words_done); end
      rst = 1'b0;
      $display("reset: released");
   endtask

   task automatic test_fill();
      int base, dbase, gbase, hbase;
      bit ok;
      base  = log_addr.size();
      dbase = done_cnt;
      gbase = gap_err;
      hbase = hold_err;
      ack_delay = 2;
      issue(1'b0, 20'h0, 20'h00010, 20'd3, 48'hA5A5A5A5A5A5);
      compared++;
      if (busy !== 1'b1 || m_stb !== 1'b1 || m_we !== 1'b1 || m_addra !== 20'h00010) begin
         mismatched++;
         $display("FAIL fill_latency got busy=%b stb=%b we=%b addr=%h want 1 1 1 00010", busy, m_stb, m_we, m_addra);
      end
      wait_done(200, ok);
      compared++;
      if (!ok) begin mismatched++; $display("FAIL fill_done_timeout got=no_done want=done"); end
      compared++;
      if (words_done !== 20'd3) begin mismatched++; $display("FAIL fill_words got=%0d want=3", words_done); end
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if (log_addr.size() - base != 3) begin
         mismatched++;
         $display("FAIL fill_count got=%0d want=3", log_addr.size() - base);
      end
      for (int i = 0; i < 3 && base + i < log_addr.size(); i++) begin
         compared++;
         if (log_we[base+i] !== 1'b1 || log_addr[base+i] !== 20'h00010 + 20'(i) || log_data[base+i] !== 48'hA5A5A5A5A5A5) begin
            mismatched++;
            $display("FAIL fill_xfer%0d got we=%b addr=%h data=%h want 1 %h a5a5a5a5a5a5", i,
                     log_we[base+i], log_addr[base+i], log_data[base+i], 20'h00010 + 20'(i));
         end
      end
      compared++;
      if (done_cnt - dbase != 1) begin mismatched++; $display("FAIL fill_done_pulses got=%0d want=1", done_cnt - dbase); end
      compared++;
      if (gap_err != gbase) begin mismatched++; $display("FAIL fill_gap got=%0d bad_gaps want=0", gap_err - gbase); end
      compared++;
      if (hold_err != hbase) begin mismatched++; $display("FAIL fill_hold got=%0d changes want=0", hold_err - hbase); end
      compared++;
      if (words_done !== 20'd3 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL fill_after got words=%0d busy=%b want 3 0", words_done, busy);
      end
      ack_delay = 1;
      $display("fill: %0d transfers logged", log_addr.size() - base);
   endtask

   task automatic test_copy();
      logic        exp_we[4];
      logic [19:0] exp_addr[4];
      logic [47:0] exp_data[4];
      int base, dbase;
      bit ok;
      exp_we   = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_addr = '{20'h00100, 20'h00200, 20'h00101, 20'h00201};
      exp_data = '{48'h0, 48'h111111111111, 48'h0, 48'h222222222222};
      base  = log_addr.size();
      dbase = done_cnt;
      issue(1'b1, 20'h00100, 20'h00200, 20'd2, 48'h0);
      compared++;
      if (m_stb !== 1'b1 || m_we !== 1'b0 || m_addra !== 20'h00100) begin
         mismatched++;
         $display("FAIL copy_first_rd got stb=%b we=%b addr=%h want 1 0 00100", m_stb, m_we, m_addra);
      end
      wait_done(200, ok);
      compared++;
      if (!ok) begin mismatched++; $display("FAIL copy_done_timeout got=no_done want=done"); end
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if (log_addr.size() - base != 4) begin
         mismatched++;
         $display("FAIL copy_count got=%0d want=4", log_addr.size() - base);
      end
      for (int i = 0; i < 4 && base + i < log_addr.size(); i++) begin
         compared++;
         if (log_we[base+i] !== exp_we[i] || log_addr[base+i] !== exp_addr[i] ||
             (exp_we[i] && log_data[base+i] !== exp_data[i])) begin
            mismatched++;
            $display("FAIL copy_xfer%0d got we=%b addr=%h data=%h want we=%b addr=%h data=%h", i,
                     log_we[base+i], log_addr[base+i], log_data[base+i], exp_we[i], exp_addr[i], exp_data[i]);
         end
      end
      compared++;
      if (busy !== 1'b0 || done_cnt - dbase != 1 || words_done !== 20'd2) begin
         mismatched++;
         $display("FAIL copy_end got busy=%b pulses=%0d words=%0d want 0 1 2", busy, done_cnt - dbase, words_done);
      end
      $display("copy: %0d transfers logged", log_addr.size() - base);
   endtask

   task automatic test_len0();
      int sbase;
      sbase = stb_cnt;
      issue(1'b0, 20'h0, 20'h00040, 20'd0, 48'h123);
      compared++;
      if (done !== 1'b1 || busy !== 1'b0 || m_stb !== 1'b0) begin
         mismatched++;
         $display("FAIL len0_edge got done=%b busy=%b stb=%b want 1 0 0", done, busy, m_stb);
      end
      compared++;
      if (words_done !== 20'd0) begin mismatched++; $display("FAIL len0_words got=%0d want=0", words_done); end
      @(posedge clk);
      #1;
      compared++;
      if (done !== 1'b0) begin mismatched++; $display("FAIL len0_done_width got=%b want=0", done); end
      repeat (4) @(posedge clk);
      #1;
      compared++;
      if (stb_cnt != sbase) begin mismatched++; $display("FAIL len0_stb got=%0d strobes want=0", stb_cnt - sbase); end
      $display("len0: done pulse seen");
   endtask

   task automatic test_wrap();
      logic [19:0] exp_addr[3];
      int base;
      bit ok;
      exp_addr = '{20'hFFFFE, 20'hFFFFF, 20'h00000};
      base = log_addr.size();
      issue(1'b0, 20'h0, 20'hFFFFE, 20'd3, 48'h123456789ABC);
      wait_done(200, ok);
      compared++;
      if (!ok) begin mismatched++; $display("FAIL wrap_done_timeout got=no_done want=done"); end
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if (log_addr.size() - base != 3) begin
         mismatched++;
         $display("FAIL wrap_count got=%0d want=3", log_addr.size() - base);
      end
      for (int i = 0; i < 3 && base + i < log_addr.size(); i++) begin
         compared++;
         if (log_addr[base+i] !== exp_addr[i] || log_data[base+i] !== 48'h123456789ABC) begin
            mismatched++;
            $display("FAIL wrap_xfer%0d got addr=%h data=%h want addr=%h data=123456789abc", i,
                     log_addr[base+i], log_data[base+i], exp_addr[i]);
         end
      end
      $display("wrap: %0d transfers logged", log_addr.size() - base);
   endtask

   task automatic test_robust();
      int base, dbase, gbase, hbase;
      bit ok;
      base  = log_addr.size();
      dbase = done_cnt;
      gbase = gap_err;
      hbase = hold_err;
      ack_delay = 10;
      spur_req++;
      issue(1'b0, 20'h0, 20'h00300, 20'd2, 48'h0F0F0F0F0F0F);
      repeat (4) @(posedge clk);
      #1;
      compared++;
      if (m_stb !== 1'b1 || m_we !== 1'b1 || m_addra !== 20'h00300 || m_dina !== 48'h0F0F0F0F0F0F) begin
         mismatched++;
         $display("FAIL robust_stall got stb=%b we=%b addr=%h dina=%h want 1 1 00300 0f0f0f0f0f0f",
                  m_stb, m_we, m_addra, m_dina);
      end
      start     = 1'b1;
      mode      = 1'b1;
      dst_addr  = 20'h00999;
      len       = 20'd5;
      fill_data = 48'hFFFF00000000;
      @(posedge clk);
      #1;
      start = 1'b0;
      compared++;
      if (m_addra !== 20'h00300 || m_we !== 1'b1 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL robust_start_busy got addr=%h we=%b busy=%b want 00300 1 1", m_addra, m_we, busy);
      end
      wait_done(300, ok);
      compared++;
      if (!ok) begin mismatched++; $display("FAIL robust_done_timeout got=no_done want=done"); end
      repeat (6) @(posedge clk);
      #1;
      compared++;
      if (log_addr.size() - base != 2) begin
         mismatched++;
         $display("FAIL robust_count got=%0d want=2", log_addr.size() - base);
      end
      for (int i = 0; i < 2 && base + i < log_addr.size(); i++) begin
         compared++;
         if (log_we[base+i] !== 1'b1 || log_addr[base+i] !== 20'h00300 + 20'(i) || log_data[base+i] !== 48'h0F0F0F0F0F0F) begin
            mismatched++;
            $display("FAIL robust_xfer%0d got we=%b addr=%h data=%h want 1 %h 0f0f0f0f0f0f", i,
                     log_we[base+i], log_addr[base+i], log_data[base+i], 20'h00300 + 20'(i));
         end
      end
      compared++;
      if (words_done !== 20'd2 || busy !== 1'b0 || done_cnt - dbase != 1) begin
         mismatched++;
         $display("FAIL robust_end got words=%0d busy=%b pulses=%0d want 2 0 1", words_done, busy, done_cnt - dbase);
      end
      compared++;
      if (hold_err != hbase || gap_err != gbase) begin
         mismatched++;
         $display("FAIL robust_protocol got hold=%0d gap=%0d want 0 0", hold_err - hbase, gap_err - gbase);
      end
      ack_delay = 1;
      $display("robust: %0d transfers logged", log_addr.size() - base);
   endtask

   task automatic test_reset_mid();
      int base, sbase;
      bit ok;
      ok = 1'b0;
      issue(1'b0, 20'h0, 20'h00400, 20'd4, 48'h00000000AAAA);
      for (int i = 0; i < 50; i++) begin
         if (words_done === 20'd1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      resp_en = 1'b0;
      compared++;
      if (!ok) begin mismatched++; $display("FAIL rstmid_first_write_timeout got words=%0d want=1", words_done); end
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if (m_stb !== 1'b1 || m_we !== 1'b1 || m_addra !== 20'h00401) begin
         mismatched++;
         $display("FAIL rstmid_waiting got stb=%b we=%b addr=%h want 1 1 00401", m_stb, m_we, m_addra);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      compared++;
      if (m_stb !== 1'b0 || busy !== 1'b0 || words_done !== 20'd0 || done !== 1'b0) begin
         mismatched++;
         $display("FAIL rstmid_abort got stb=%b busy=%b words=%0d done=%b want 0 0 0 0", m_stb, busy, words_done, done);
      end
      sbase = stb_cnt;
      resp_en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      compared++;
      if (stb_cnt != sbase || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL rstmid_no_resume got strobes=%0d busy=%b want 0 0", stb_cnt - sbase, busy);
      end
      base = log_addr.size();
      issue(1'b0, 20'h0, 20'h00500, 20'd2, 48'h00000000BBBB);
      wait_done(200, ok);
      compared++;
      if (!ok) begin mismatched++; $display("FAIL rstmid_restart_timeout got=no_done want=done"); end
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if (log_addr.size() - base != 2 || words_done !== 20'd2) begin
         mismatched++;
         $display("FAIL rstmid_restart got xfers=%0d words=%0d want 2 2", log_addr.size() - base, words_done);
      end
      for (int i = 0; i < 2 && base + i < log_addr.size(); i++) begin
         compared++;
         if (log_addr[base+i] !== 20'h00500 + 20'(i) || log_data[base+i] !== 48'h00000000BBBB) begin
            mismatched++;
            $display("FAIL rstmid_xfer%0d got addr=%h data=%h want %h 00000000bbbb", i,
                     log_addr[base+i], log_data[base+i], 20'h00500 + 20'(i));
         end
      end
      $display("reset_mid: restart logged %0d transfers", log_addr.size() - base);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      mode      = 1'b0;
      src_addr  = '0;
      dst_addr  = '0;
      len       = '0;
      fill_data = '0;
      test_reset();
      test_fill();
      test_copy();
      test_len0();
      test_wrap();
      test_robust();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
